// File: rtl/ifetch_queue.sv
// ifetch_queue: in-order instruction fetch unit with a prefetch FIFO.
//
// Owns the fetch PC and issues word-aligned requests to a variable-latency
// instruction memory. Responses return in request order. Each response is
// paired with the PC of its request from a small PC FIFO. The pair is then
// queued for the core, which takes one instruction per cycle. A redirect
// flushes the queue. Responses still in flight are counted and dropped.
//
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a response
// that arrives while the queue is empty goes straight to the core outputs
// in the same cycle.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel
//   imem_resp_valid/data           in-order fetch responses
//   core_valid/ready/instr/pc      head-of-queue instruction to the core
//   redirect, redirect_pc          flush and restart fetch at redirect_pc
module ifetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        core_valid,
  input  logic        core_ready,
  output logic [31:0] core_instr,
  output logic [31:0] core_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] discard_cnt_q, discard_cnt_d;
  logic [PW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [PW-1:0] pc_head_q, pc_head_d, pc_tail_q, pc_tail_d;

  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_pc_q    [DEPTH];
  logic [31:0]   pcf_q     [DEPTH];

  logic          run;
  logic          req_fire;
  logic          resp_ok;
  logic [31:0]   resp_pc;
  logic          byp_hit;
  logic          byp_take;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding;
  logic          q_nonempty;
  logic          unused_redirect_lsbs;

  // Bits [1:0] of the redirect target are forced to zero.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign run        = (state_q == ST_RUN);
  assign q_nonempty = (count_q != '0);

  // Credit rule: queued plus in-flight never exceeds DEPTH.
  assign imem_req_valid = run && ((SW'(in_flight_q) + SW'(count_q)) < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response is only meaningful in RUN with a request outstanding.
  assign resp_ok = run & imem_resp_valid & (in_flight_q != '0);
  assign resp_pc = pcf_q[pc_head_q];

`ifdef IFQ_BYPASS_EN
  assign byp_hit = resp_ok & ~redirect & ~q_nonempty;
`else
  assign byp_hit = 1'b0;
`endif
  assign byp_take = byp_hit & core_ready;

  // Redirect wins over same-cycle push and pop.
  assign push = resp_ok & ~redirect & ~byp_take;
  assign pop  = q_nonempty & core_ready & ~redirect;

  // Core outputs come from the queue head, or from the response in bypass.
  always_comb begin
    core_valid = q_nonempty | byp_hit;
    core_instr = NOP_INSTR;
    core_pc    = 32'h0000_0000;
    if (q_nonempty) begin
      core_instr = q_instr_q[q_head_q];
      core_pc    = q_pc_q[q_head_q];
    end else if (byp_hit) begin
      core_instr = imem_resp_data;
      core_pc    = resp_pc;
    end
  end

  // Responses still owed by memory at a redirect, including one accepted
  // in this cycle and excluding one that returns in this cycle.
  always_comb begin
    outstanding = '0;
    if (state_q == ST_RUN) begin
      outstanding = in_flight_q + CW'(req_fire) - CW'(resp_ok);
    end else if (state_q == ST_FLUSH) begin
      outstanding = discard_cnt_q - CW'(imem_resp_valid && (discard_cnt_q != '0));
    end
  end

  // Next-state logic for the FSM, counters and FIFO pointers.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    in_flight_d   = in_flight_q;
    discard_cnt_d = discard_cnt_q;
    q_head_d      = q_head_q;
    q_tail_d      = q_tail_q;
    pc_head_d     = pc_head_q;
    pc_tail_d     = pc_tail_q;
    unique case (state_q)
      ST_RESET: state_d = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (redirect) begin
          fetch_pc_d    = {redirect_pc[31:2], 2'b00};
          count_d       = '0;
          in_flight_d   = '0;
          q_head_d      = '0;
          q_tail_d      = '0;
          pc_head_d     = '0;
          pc_tail_d     = '0;
          discard_cnt_d = outstanding;
          state_d       = (outstanding == '0) ? ST_RUN : ST_FLUSH;
        end else if (state_q == ST_RUN) begin
          count_d     = count_q + CW'(push) - CW'(pop);
          q_tail_d    = q_tail_q + PW'(push);
          q_head_d    = q_head_q + PW'(pop);
          in_flight_d = in_flight_q + CW'(req_fire) - CW'(resp_ok);
          pc_tail_d   = pc_tail_q + PW'(req_fire);
          pc_head_d   = pc_head_q + PW'(resp_ok);
          if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end else if (imem_resp_valid) begin
          // FLUSH: drop this response; resume once the last one is gone.
          discard_cnt_d = discard_cnt_q - CW'(1);
          if (discard_cnt_d == '0) begin
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      in_flight_q   <= '0;
      discard_cnt_q <= '0;
      q_head_q      <= '0;
      q_tail_q      <= '0;
      pc_head_q     <= '0;
      pc_tail_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      in_flight_q   <= in_flight_d;
      discard_cnt_q <= discard_cnt_d;
      q_head_q      <= q_head_d;
      q_tail_q      <= q_tail_d;
      pc_head_q     <= pc_head_d;
      pc_tail_q     <= pc_tail_d;
    end
  end

  // FIFO storage. Pointers and counters qualify the contents, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr_q[q_tail_q] <= imem_resp_data;
      q_pc_q[q_tail_q]    <= resp_pc;
    end
    if (req_fire) begin
      pcf_q[pc_tail_q] <= fetch_pc_q;
    end
  end

endmodule
